matrix_bank: RTL and testbench
==============================

MATRIX_BANK -- requirements
Module: matrix_bank

Interface
REQ-001 SHALL have parameter MAX_DIM, default 5, max rows/cols per matrix.
REQ-002 SHALL have parameter SLOTS_PER_DIM, default 4, slots per (m,n) combo, legal 1..8.
REQ-003 SHALL have parameter ELEM_WIDTH, default 8, element bits.
REQ-004 SHALL have parameter DIM_BITS, default 3, row/col index width.
REQ-005 SHALL have ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- wr_start  in  1  begin session.
- wr_m, wr_n  in  4  dims.
- wr_data  in  ELEM_WIDTH  element.
- wr_valid  in  1  element strobe.
- wr_ready  out  1  element accepted.
- wr_finish  in  1  end session early.
- wr_done  out  1  one-cycle commit pulse.
- wr_slot  out  3  slot committed.
- wr_err  out  1  one-cycle illegal-dims pulse.
- rd_req  in  1  read request, every high cycle.
- rd_m, rd_n  in  4  dims.
- rd_slot  in  3  slot.
- rd_row, rd_col  in  DIM_BITS  index.
- rd_data  out  ELEM_WIDTH  data.
- rd_valid  out  1  data good.
- rd_err  out  1  bad request.
- q_m, q_n  in  4  query dims.
- q_mask  out  SLOTS_PER_DIM  valid-slot mask.
- q_count  out  4  popcount of q_mask.
- busy  out  1  FSM not IDLE.

Function
REQ-006 FSM SHALL have states IDLE, WRITE, PAD, COMMIT.
REQ-007 IDLE + wr_start with 1<=wr_m,wr_n<=MAX_DIM SHALL latch dims, pick target slot, go WRITE next cycle; illegal dims SHALL pulse wr_err and stay IDLE.
REQ-008 Target slot SHALL be the lowest-index invalid slot of the combo, else the combo's round-robin pointer (wraps SLOTS_PER_DIM-1 -> 0).
REQ-009 wr_ready SHALL be high only in WRITE; element stored row-major when wr_valid && wr_ready.
REQ-010 After m*n elements, SHALL go COMMIT; wr_data beyond m*n never written.
REQ-011 wr_finish in WRITE with count<m*n SHALL go PAD (macro on) or COMMIT with missing elements undefined (macro off).
REQ-012 COMMIT SHALL, for one cycle, set slot valid bit, advance pointer only if slot was replaced, pulse wr_done with wr_slot, return IDLE.
REQ-013 Valid bit of target slot SHALL be cleared at session start, so a partially written matrix is never readable.
REQ-014 wr_start outside IDLE SHALL be ignored.
REQ-015 Reads SHALL have 1-cycle latency; rd_valid=1 next cycle iff dims legal, slot<SLOTS_PER_DIM, valid bit set, rd_row<rd_m, rd_col<rd_n; otherwise rd_err=1, rd_data=0.
REQ-016 Read same cycle as COMMIT of same slot SHALL report invalid (pre-commit state).
REQ-017 q_mask/q_count SHALL be combinational; illegal query dims give 0.
REQ-018 Reads and queries SHALL operate in any FSM state.

Reset
REQ-019 rst SHALL clear all valid bits and pointers, FSM->IDLE, all outputs 0; mid-session data discarded, no wr_done.
REQ-020 Storage contents SHALL not be reset.

Configuration
REQ-021 MATRIX_BANK_ZERO_PAD_EN defined: PAD writes 0 to each remaining element, one per cycle, then COMMIT; undefined: PAD state absent, wr_finish goes straight to COMMIT.

Structure
REQ-022 Package matrix_pkg SHALL hold the state enum, MAX_DIM, DIM_BITS, and the combo-index function (m-1)*MAX_DIM+(n-1).
REQ-023 Sub-module matrix_slot_alloc SHALL hold per-combo valid bits, pointers, and slot choice.

Verification
REQ-024 Write 2x3, elements 1..6 -> wr_done, wr_slot=0; read (1,2) -> rd_data=6 one cycle later.
REQ-025 Five 2x2 writes, SLOTS_PER_DIM=4 -> slots 0,1,2,3,0; q_count=4.
REQ-026 Write 3x3, 4 elements, wr_finish, macro on -> 5 PAD cycles; read (2,2)=0.
REQ-027 wr_m=6 -> wr_err pulse, busy stays 0; read slot 5 -> rd_err.
REQ-028 rst mid-session after 3 elements -> no wr_done, q_mask=0.
REQ-029 Re-write of a valid slot: reading it during WRITE -> rd_err.

Source files
------------

// File: rtl/matrix_pkg.sv
// -----------------------------------------------------------------------------
// matrix_pkg
// Shared definitions for the matrix bank:
//   - bank_state_e : write-session FSM states (PAD exists only when
//                    MATRIX_BANK_ZERO_PAD_EN is defined)
//   - MAX_DIM      : largest row/column count of a stored matrix
//   - DIM_BITS     : width of a row/column index
//   - SLOT_W       : width of a slot number on the external ports
//   - combo_idx()  : maps legal dims (m,n) to a dense combo index
//   - dims_legal() : 1 <= m,n <= max_dim
// -----------------------------------------------------------------------------
package matrix_pkg;

    localparam int MAX_DIM  = 5;
    localparam int DIM_BITS = 3;
    localparam int SLOT_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
`ifdef MATRIX_BANK_ZERO_PAD_EN
        PAD    = 2'd2,
`endif
        COMMIT = 2'd3
    } bank_state_e;

    // Only meaningful for legal dims; callers gate on dims_legal().
    function automatic int unsigned combo_idx(input logic [3:0] m,
                                              input logic [3:0] n,
                                              input int unsigned max_dim);
        return (32'(m) - 32'd1) * max_dim + (32'(n) - 32'd1);
    endfunction

    function automatic logic dims_legal(input logic [3:0] m,
                                        input logic [3:0] n,
                                        input int unsigned max_dim);
        return (m != 4'd0) && (n != 4'd0) &&
               (32'(m) <= max_dim) && (32'(n) <= max_dim);
    endfunction

endpackage

// File: rtl/matrix_bank_if.sv
// -----------------------------------------------------------------------------
// matrix_bank_if
// Bundles the write-session, read and query signals of matrix_bank.
//   write : wr_start, wr_m, wr_n, wr_data, wr_valid, wr_finish (to bank)
//           wr_ready, wr_done, wr_slot, wr_err                (from bank)
//   read  : rd_req, rd_m, rd_n, rd_slot, rd_row, rd_col       (to bank)
//           rd_data, rd_valid, rd_err                         (from bank)
//   query : q_m, q_n (to bank); q_mask, q_count (from bank)
//   status: busy (from bank)
// Modports: slave = bank side, master = user side.
// -----------------------------------------------------------------------------
interface matrix_bank_if #(
    parameter int ELEM_WIDTH    = 8,
    parameter int SLOTS_PER_DIM = 4,
    parameter int DIM_BITS      = 3
);
    logic                     wr_start;
    logic [3:0]               wr_m;
    logic [3:0]               wr_n;
    logic [ELEM_WIDTH-1:0]    wr_data;
    logic                     wr_valid;
    logic                     wr_ready;
    logic                     wr_finish;
    logic                     wr_done;
    logic [2:0]               wr_slot;
    logic                     wr_err;

    logic                     rd_req;
    logic [3:0]               rd_m;
    logic [3:0]               rd_n;
    logic [2:0]               rd_slot;
    logic [DIM_BITS-1:0]      rd_row;
    logic [DIM_BITS-1:0]      rd_col;
    logic [ELEM_WIDTH-1:0]    rd_data;
    logic                     rd_valid;
    logic                     rd_err;

    logic [3:0]               q_m;
    logic [3:0]               q_n;
    logic [SLOTS_PER_DIM-1:0] q_mask;
    logic [3:0]               q_count;

    logic                     busy;

    modport slave (
        input  wr_start, wr_m, wr_n, wr_data, wr_valid, wr_finish,
        output wr_ready, wr_done, wr_slot, wr_err,
        input  rd_req, rd_m, rd_n, rd_slot, rd_row, rd_col,
        output rd_data, rd_valid, rd_err,
        input  q_m, q_n,
        output q_mask, q_count,
        output busy
    );

    modport master (
        output wr_start, wr_m, wr_n, wr_data, wr_valid, wr_finish,
        input  wr_ready, wr_done, wr_slot, wr_err,
        output rd_req, rd_m, rd_n, rd_slot, rd_row, rd_col,
        input  rd_data, rd_valid, rd_err,
        output q_m, q_n,
        input  q_mask, q_count,
        input  busy
    );
endinterface

// File: rtl/matrix_slot_alloc.sv
// -----------------------------------------------------------------------------
// matrix_slot_alloc
// Per-(m,n)-combo slot bookkeeping: valid bits, round-robin replacement
// pointers and the choice of the target slot for a new write session.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   alloc_combo_i     : combo of the session being started
//   alloc_slot_o      : lowest invalid slot, else the round-robin pointer
//   alloc_replace_o   : 1 when alloc_slot_o overwrites a valid slot
//   start_i           : clear valid bit of alloc_slot_o in alloc_combo_i
//   commit_i/*_combo_i/*_slot_i/*_replace_i : set valid bit, step pointer
//   q_combo_i/q_valid_o  : valid mask of a combo
//   rd_combo_i/rd_slot_i/rd_valid_o : valid bit of one slot
// -----------------------------------------------------------------------------
module matrix_slot_alloc
    import matrix_pkg::*;
#(
    parameter int NUM_COMBOS    = 25,
    parameter int SLOTS_PER_DIM = 4,
    parameter int COMBO_W       = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [COMBO_W-1:0]       alloc_combo_i,
    output logic [SLOT_W-1:0]        alloc_slot_o,
    output logic                     alloc_replace_o,
    input  logic                     start_i,
    input  logic                     commit_i,
    input  logic [COMBO_W-1:0]       commit_combo_i,
    input  logic [SLOT_W-1:0]        commit_slot_i,
    input  logic                     commit_replace_i,
    input  logic [COMBO_W-1:0]       q_combo_i,
    output logic [SLOTS_PER_DIM-1:0] q_valid_o,
    input  logic [COMBO_W-1:0]       rd_combo_i,
    input  logic [SLOT_W-1:0]        rd_slot_i,
    output logic                     rd_valid_o
);

    // One-hot of a slot number; slot numbers >= SLOTS_PER_DIM map to zero.
    function automatic logic [SLOTS_PER_DIM-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        logic [SLOTS_PER_DIM-1:0] oh;
        for (int i = 0; i < SLOTS_PER_DIM; i++) begin
            oh[i] = (s == SLOT_W'(i));
        end
        return oh;
    endfunction

    logic [NUM_COMBOS-1:0][SLOTS_PER_DIM-1:0] valid_all;
    logic [NUM_COMBOS-1:0][SLOT_W-1:0]        ptr_all;
    logic [SLOTS_PER_DIM-1:0]                 clr_mask;
    logic [SLOTS_PER_DIM-1:0]                 set_mask;
    logic [SLOTS_PER_DIM-1:0]                 cur_valid;
    logic [SLOT_W-1:0]                        cur_ptr;

    assign clr_mask = slot_onehot(alloc_slot_o);
    assign set_mask = slot_onehot(commit_slot_i);

    for (genvar gi = 0; gi < NUM_COMBOS; gi++) begin : g_combo
        logic [SLOTS_PER_DIM-1:0] valid_q;
        logic [SLOT_W-1:0]        ptr_q;
        logic                     clr_hit;
        logic                     set_hit;

        assign clr_hit = start_i  && (alloc_combo_i  == COMBO_W'(gi));
        assign set_hit = commit_i && (commit_combo_i == COMBO_W'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                valid_q <= '0;
                ptr_q   <= '0;
            end else if (clr_hit) begin
                valid_q <= valid_q & ~clr_mask;
            end else if (set_hit) begin
                valid_q <= valid_q | set_mask;
                // Pointer only moves when a live matrix was evicted.
                if (commit_replace_i) begin
                    ptr_q <= (ptr_q == SLOT_W'(SLOTS_PER_DIM - 1)) ? '0 : ptr_q + SLOT_W'(1);
                end
            end
        end

        assign valid_all[gi] = valid_q;
        assign ptr_all[gi]   = ptr_q;
    end

    always_comb begin
        cur_valid = '0;
        cur_ptr   = '0;
        if (int'(alloc_combo_i) < NUM_COMBOS) begin
            cur_valid = valid_all[alloc_combo_i];
            cur_ptr   = ptr_all[alloc_combo_i];
        end
        alloc_slot_o    = cur_ptr;
        alloc_replace_o = 1'b1;
        // Descending scan so the lowest free slot is the one left standing.
        for (int s = SLOTS_PER_DIM - 1; s >= 0; s--) begin
            if (!cur_valid[s]) begin
                alloc_slot_o    = SLOT_W'(s);
                alloc_replace_o = 1'b0;
            end
        end
    end

    always_comb begin
        q_valid_o  = '0;
        rd_valid_o = 1'b0;
        if (int'(q_combo_i) < NUM_COMBOS) begin
            q_valid_o = valid_all[q_combo_i];
        end
        if (int'(rd_combo_i) < NUM_COMBOS) begin
            rd_valid_o = |(valid_all[rd_combo_i] & slot_onehot(rd_slot_i));
        end
    end

endmodule

// File: rtl/matrix_bank.sv
// -----------------------------------------------------------------------------
// matrix_bank
// Stores small matrices (up to MAX_DIM x MAX_DIM) in SLOTS_PER_DIM slots per
// (m,n) combination. A write session streams elements row-major and commits
// the matrix to a slot; reads return one element with one cycle of latency;
// queries report which slots of a combination hold a valid matrix.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (storage contents are kept)
//   bus  : matrix_bank_if.slave (write session, read, query, busy)
// Build option:
//   MATRIX_BANK_ZERO_PAD_EN : when defined, an early wr_finish zero-fills the
//   remaining elements (PAD state) before committing; otherwise the session
//   commits at once and the unwritten elements are undefined.
// -----------------------------------------------------------------------------
module matrix_bank #(
    parameter int MAX_DIM       = matrix_pkg::MAX_DIM,
    parameter int SLOTS_PER_DIM = 4,
    parameter int ELEM_WIDTH    = 8,
    parameter int DIM_BITS      = matrix_pkg::DIM_BITS
) (
    input  logic         clk,
    input  logic         rst,
    matrix_bank_if.slave bus
);
    import matrix_pkg::*;

    localparam int NUM_COMBOS = MAX_DIM * MAX_DIM;
    localparam int COMBO_W    = (NUM_COMBOS > 1) ? $clog2(NUM_COMBOS) : 1;
    localparam int MAT_SIZE   = MAX_DIM * MAX_DIM;
    localparam int DEPTH      = NUM_COMBOS * SLOTS_PER_DIM * MAT_SIZE;
    localparam int ADDR_W     = $clog2(DEPTH);

    // Each matrix owns a MAX_DIM x MAX_DIM tile; elements sit row-major in it.
    function automatic logic [ADDR_W-1:0] elem_addr(input logic [COMBO_W-1:0]  combo,
                                                    input logic [SLOT_W-1:0]   slot,
                                                    input logic [DIM_BITS-1:0] row,
                                                    input logic [DIM_BITS-1:0] col);
        int unsigned a;
        a = (32'(combo) * SLOTS_PER_DIM + 32'(slot)) * MAT_SIZE
            + 32'(row) * MAX_DIM + 32'(col);
        return ADDR_W'(a);
    endfunction

    bank_state_e          state_q, state_d;
    logic [3:0]           m_q, m_d;
    logic [3:0]           n_q, n_d;
    logic [COMBO_W-1:0]   combo_q, combo_d;
    logic [SLOT_W-1:0]    slot_q, slot_d;
    logic                 replace_q, replace_d;
    logic [DIM_BITS-1:0]  row_q, row_d;
    logic [DIM_BITS-1:0]  col_q, col_d;
    logic                 wr_err_q, wr_err_d;

    logic                 mem_we;
    logic [ELEM_WIDTH-1:0] mem_wdata;
    logic                 alloc_start;
    logic                 commit;
    logic [SLOT_W-1:0]    alloc_slot;
    logic                 alloc_replace;

    logic                 wr_dims_ok;
    logic [COMBO_W-1:0]   wr_combo;
    logic                 row_last, col_last, last_elem;
    logic [DIM_BITS-1:0]  next_row, next_col;
    logic [ADDR_W-1:0]    wr_addr;

    logic                 rd_dims_ok;
    logic [COMBO_W-1:0]   rd_combo;
    logic                 rd_slot_valid;
    logic                 rd_ok;
    logic [ADDR_W-1:0]    rd_addr;
    logic                 rd_valid_q;
    logic                 rd_err_q;
    logic [ELEM_WIDTH-1:0] rd_mem_q;

    logic [COMBO_W-1:0]   q_combo;
    logic [SLOTS_PER_DIM-1:0] q_valid;
    logic [SLOTS_PER_DIM-1:0] q_mask_w;
    logic [3:0]           q_cnt;

    logic [ELEM_WIDTH-1:0] mem_q [DEPTH];

    // ---------------- write session ----------------
    assign wr_dims_ok = dims_legal(bus.wr_m, bus.wr_n, MAX_DIM);
    assign wr_combo   = COMBO_W'(combo_idx(bus.wr_m, bus.wr_n, MAX_DIM));

    assign col_last  = (int'(col_q) == int'(n_q) - 1);
    assign row_last  = (int'(row_q) == int'(m_q) - 1);
    assign last_elem = row_last && col_last;
    assign next_col  = col_last ? '0 : col_q + DIM_BITS'(1);
    assign next_row  = col_last ? row_q + DIM_BITS'(1) : row_q;
    assign wr_addr   = elem_addr(combo_q, slot_q, row_q, col_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            m_q       <= '0;
            n_q       <= '0;
            combo_q   <= '0;
            slot_q    <= '0;
            replace_q <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            n_q       <= n_d;
            combo_q   <= combo_d;
            slot_q    <= slot_d;
            replace_q <= replace_d;
            row_q     <= row_d;
            col_q     <= col_d;
            wr_err_q  <= wr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        n_d         = n_q;
        combo_d     = combo_q;
        slot_d      = slot_q;
        replace_d   = replace_q;
        row_d       = row_q;
        col_d       = col_q;
        wr_err_d    = 1'b0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        alloc_start = 1'b0;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.wr_start) begin
                    if (wr_dims_ok) begin
                        m_d         = bus.wr_m;
                        n_d         = bus.wr_n;
                        combo_d     = wr_combo;
                        slot_d      = alloc_slot;
                        replace_d   = alloc_replace;
                        row_d       = '0;
                        col_d       = '0;
                        // Invalidate now so a half-written matrix is never read.
                        alloc_start = 1'b1;
                        state_d     = WRITE;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (bus.wr_valid) begin
                    mem_we    = 1'b1;
                    mem_wdata = bus.wr_data;
                    if (last_elem) begin
                        state_d = COMMIT;
                    end else begin
                        row_d = next_row;
                        col_d = next_col;
                    end
                end
                // An element accepted alongside wr_finish still counts.
                if (bus.wr_finish && !(bus.wr_valid && last_elem)) begin
`ifdef MATRIX_BANK_ZERO_PAD_EN
                    state_d = PAD;
`else
                    state_d = COMMIT;
`endif
                end
            end
`ifdef MATRIX_BANK_ZERO_PAD_EN
            PAD: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                if (last_elem) begin
                    state_d = COMMIT;
                end else begin
                    row_d = next_row;
                    col_d = next_col;
                end
            end
`endif
            COMMIT: begin
                commit  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_addr] <= mem_wdata;
        end
        if (bus.rd_req) begin
            rd_mem_q <= mem_q[rd_addr];
        end
    end

    // ---------------- read path ----------------
    assign rd_dims_ok = dims_legal(bus.rd_m, bus.rd_n, MAX_DIM);
    assign rd_combo   = COMBO_W'(combo_idx(bus.rd_m, bus.rd_n, MAX_DIM));
    // Valid bits are registered, so a read in the COMMIT cycle sees pre-commit state.
    assign rd_ok = rd_dims_ok && (int'(bus.rd_slot) < SLOTS_PER_DIM) && rd_slot_valid &&
                   (int'(bus.rd_row) < int'(bus.rd_m)) && (int'(bus.rd_col) < int'(bus.rd_n));
    assign rd_addr = rd_ok ? elem_addr(rd_combo, bus.rd_slot, bus.rd_row, bus.rd_col) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= bus.rd_req && rd_ok;
            rd_err_q   <= bus.rd_req && !rd_ok;
        end
    end

    // ---------------- query ----------------
    assign q_combo  = COMBO_W'(combo_idx(bus.q_m, bus.q_n, MAX_DIM));
    assign q_mask_w = dims_legal(bus.q_m, bus.q_n, MAX_DIM) ? q_valid : '0;

    always_comb begin
        q_cnt = '0;
        for (int s = 0; s < SLOTS_PER_DIM; s++) begin
            q_cnt = q_cnt + 4'(q_mask_w[s]);
        end
    end

    matrix_slot_alloc #(
        .NUM_COMBOS    (NUM_COMBOS),
        .SLOTS_PER_DIM (SLOTS_PER_DIM),
        .COMBO_W       (COMBO_W)
    ) u_alloc (
        .clk              (clk),
        .rst              (rst),
        .alloc_combo_i    (wr_combo),
        .alloc_slot_o     (alloc_slot),
        .alloc_replace_o  (alloc_replace),
        .start_i          (alloc_start),
        .commit_i         (commit),
        .commit_combo_i   (combo_q),
        .commit_slot_i    (slot_q),
        .commit_replace_i (replace_q),
        .q_combo_i        (q_combo),
        .q_valid_o        (q_valid),
        .rd_combo_i       (rd_combo),
        .rd_slot_i        (bus.rd_slot),
        .rd_valid_o       (rd_slot_valid)
    );

    // ---------------- outputs ----------------
    assign bus.wr_ready = (state_q == WRITE);
    assign bus.wr_done  = (state_q == COMMIT);
    assign bus.wr_slot  = (state_q == COMMIT) ? slot_q : '0;
    assign bus.wr_err   = wr_err_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_err   = rd_err_q;
    assign bus.rd_data  = rd_valid_q ? rd_mem_q : '0;
    assign bus.q_mask   = q_mask_w;
    assign bus.q_count  = q_cnt;

endmodule

// File: tb/tb_matrix_bank.sv
// -----------------------------------------------------------------------------
// tb_matrix_bank
// Directed bench for matrix_bank: read vectors from a table plus hand-written
// sequences for allocation order, padding, illegal dims, reset mid-session,
// rewrite of a live slot and read-during-commit.
// -----------------------------------------------------------------------------
module tb_matrix_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    matrix_bank_if #(.ELEM_WIDTH(8), .SLOTS_PER_DIM(4), .DIM_BITS(3)) bus ();

    matrix_bank #(
        .MAX_DIM       (5),
        .SLOTS_PER_DIM (4),
        .ELEM_WIDTH    (8),
        .DIM_BITS      (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [3:0] m;
        logic [3:0] n;
        logic [2:0] slot;
        logic [2:0] row;
        logic [2:0] col;
        logic       exp_v;
        logic       exp_e;
        logic [7:0] exp_d;
    } rd_vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end else begin
            $display("ok   %s: %0d", nm, act);
        end
    endtask

    task automatic do_read(input rd_vec_t v);
        bus.rd_req  = 1'b1;
        bus.rd_m    = v.m;
        bus.rd_n    = v.n;
        bus.rd_slot = v.slot;
        bus.rd_row  = v.row;
        bus.rd_col  = v.col;
        step();
        bus.rd_req = 1'b0;
        chk({v.name, ".valid"}, int'(bus.rd_valid), int'(v.exp_v));
        chk({v.name, ".err"},   int'(bus.rd_err),   int'(v.exp_e));
        chk({v.name, ".data"},  int'(bus.rd_data),  int'(v.exp_d));
    endtask

    // Full write session; returns committed slot and the cycles spent
    // waiting for wr_done after the last stimulus beat.
    task automatic write_mat(input int m, input int n, input int cnt, input int base,
                             input bit fin, output int slot, output int wait_cyc);
        bus.wr_start = 1'b1;
        bus.wr_m     = 4'(m);
        bus.wr_n     = 4'(n);
        step();
        bus.wr_start = 1'b0;
        for (int k = 0; k < cnt; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(base + k);
            step();
        end
        bus.wr_valid = 1'b0;
        if (fin) begin
            bus.wr_finish = 1'b1;
            step();
            bus.wr_finish = 1'b0;
            chk("wr_ready_after_finish", int'(bus.wr_ready), 0);
        end
        wait_cyc = 0;
        while (!bus.wr_done && wait_cyc < 40) begin
            step();
            wait_cyc++;
        end
        chk($sformatf("wr_done_%0dx%0d", m, n), int'(bus.wr_done), 1);
        slot = int'(bus.wr_slot);
        step();
    endtask

    rd_vec_t rv [12];
    int      slot_got;
    int      wcyc;
    int      exp_slots [5];
    bit      seen;

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        exp_slots = '{0, 1, 2, 3, 0};
        rv[0]  = '{"rd_2x3_r1c2",     4'd2, 4'd3, 3'd0, 3'd1, 3'd2, 1'b1, 1'b0, 8'd6};
        rv[1]  = '{"rd_2x3_r0c0",     4'd2, 4'd3, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 8'd1};
        rv[2]  = '{"rd_2x3_r1c0",     4'd2, 4'd3, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0, 8'd4};
        rv[3]  = '{"rd_2x3_r0c2",     4'd2, 4'd3, 3'd0, 3'd0, 3'd2, 1'b1, 1'b0, 8'd3};
        rv[4]  = '{"rd_invalid_slot", 4'd2, 4'd3, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0};
        rv[5]  = '{"rd_slot5",        4'd2, 4'd3, 3'd5, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0};
        rv[6]  = '{"rd_row_oob",      4'd2, 4'd3, 3'd0, 3'd2, 3'd0, 1'b0, 1'b1, 8'd0};
        rv[7]  = '{"rd_col_oob",      4'd2, 4'd3, 3'd0, 3'd0, 3'd3, 1'b0, 1'b1, 8'd0};
        rv[8]  = '{"rd_m6",           4'd6, 4'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0};
        rv[9]  = '{"rd_m0",           4'd0, 4'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0};
        rv[10] = '{"rd_other_combo",  4'd3, 4'd2, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0};
        rv[11] = '{"rd_n6",           4'd2, 4'd6, 3'd0, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0};

        bus.wr_start = 1'b0; bus.wr_m = '0; bus.wr_n = '0; bus.wr_data = '0;
        bus.wr_valid = 1'b0; bus.wr_finish = 1'b0;
        bus.rd_req = 1'b0; bus.rd_m = '0; bus.rd_n = '0; bus.rd_slot = '0;
        bus.rd_row = '0; bus.rd_col = '0;
        bus.q_m = 4'd2; bus.q_n = 4'd3;

        // Reset state
        step(); step(); step();
        rst = 1'b0;
        chk("rst_busy",     int'(bus.busy),     0);
        chk("rst_wr_ready", int'(bus.wr_ready), 0);
        chk("rst_wr_done",  int'(bus.wr_done),  0);
        chk("rst_wr_err",   int'(bus.wr_err),   0);
        chk("rst_rd_valid", int'(bus.rd_valid), 0);
        chk("rst_q_mask",   int'(bus.q_mask),   0);
        chk("rst_q_count",  int'(bus.q_count),  0);

        // 2x3 write of 1..6, then table of reads
        write_mat(2, 3, 6, 1, 1'b0, slot_got, wcyc);
        chk("w2x3_slot", slot_got, 0);
        chk("w2x3_wait", wcyc, 0);
        chk("w2x3_busy_after", int'(bus.busy), 0);
        for (int i = 0; i < 12; i++) begin
            do_read(rv[i]);
        end
        chk("q2x3_mask",  int'(bus.q_mask),  1);
        chk("q2x3_count", int'(bus.q_count), 1);

        // Five 2x2 writes: free slots first, then round-robin from 0
        for (int i = 0; i < 5; i++) begin
            write_mat(2, 2, 4, 16 * (i + 1), 1'b0, slot_got, wcyc);
            chk($sformatf("w2x2_%0d_slot", i), slot_got, exp_slots[i]);
        end
        bus.q_m = 4'd2; bus.q_n = 4'd2; #1;
        chk("q2x2_mask",  int'(bus.q_mask),  15);
        chk("q2x2_count", int'(bus.q_count), 4);
        do_read('{"rd_2x2_s0_r1c1", 4'd2, 4'd2, 3'd0, 3'd1, 3'd1, 1'b1, 1'b0, 8'd83});
        do_read('{"rd_2x2_s3_r0c1", 4'd2, 4'd2, 3'd3, 3'd0, 3'd1, 1'b1, 1'b0, 8'd65});

        // Rewrite of live slot 1 (pointer now at 1); stray wr_start ignored
        bus.wr_start = 1'b1; bus.wr_m = 4'd2; bus.wr_n = 4'd2;
        step();
        bus.wr_m = 4'd1; bus.wr_n = 4'd1;   // wr_start kept high: must be ignored
        chk("rw_wr_ready", int'(bus.wr_ready), 1);
        do_read('{"rd_during_write", 4'd2, 4'd2, 3'd1, 3'd0, 3'd0, 1'b0, 1'b1, 8'd0});
        for (int k = 0; k < 4; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(160 + k);
            step();
        end
        bus.wr_valid = 1'b0;
        bus.wr_start = 1'b0;
        chk("rw_wr_done", int'(bus.wr_done), 1);
        chk("rw_wr_slot", int'(bus.wr_slot), 1);
        // Read in the COMMIT cycle sees the slot still invalid
        do_read('{"rd_at_commit", 4'd2, 4'd2, 3'd1, 3'd1, 3'd1, 1'b0, 1'b1, 8'd0});
        do_read('{"rd_after_commit", 4'd2, 4'd2, 3'd1, 3'd1, 3'd1, 1'b1, 1'b0, 8'd163});
        bus.q_m = 4'd1; bus.q_n = 4'd1; #1;
        chk("q1x1_mask_untouched", int'(bus.q_mask), 0);

        // Illegal dims
        bus.wr_start = 1'b1; bus.wr_m = 4'd6; bus.wr_n = 4'd2;
        step();
        bus.wr_start = 1'b0;
        chk("m6_wr_err", int'(bus.wr_err), 1);
        chk("m6_busy",   int'(bus.busy),   0);
        step();
        chk("m6_wr_err_pulse_end", int'(bus.wr_err), 0);
        chk("m6_busy_after",       int'(bus.busy),   0);
        bus.q_m = 4'd6; bus.q_n = 4'd2; #1;
        chk("q_illegal_mask", int'(bus.q_mask), 0);

        // 3x3 with 4 elements then early finish
        write_mat(3, 3, 4, 48, 1'b1, slot_got, wcyc);
        chk("w3x3_slot", slot_got, 0);
`ifdef MATRIX_BANK_ZERO_PAD_EN
        chk("w3x3_pad_cycles", wcyc, 5);
        do_read('{"rd_3x3_pad_r2c2", 4'd3, 4'd3, 3'd0, 3'd2, 3'd2, 1'b1, 1'b0, 8'd0});
`else
        chk("w3x3_commit_wait", wcyc, 0);
        bus.rd_req = 1'b1; bus.rd_m = 4'd3; bus.rd_n = 4'd3; bus.rd_slot = 3'd0;
        bus.rd_row = 3'd2; bus.rd_col = 3'd2;
        step();
        bus.rd_req = 1'b0;
        chk("rd_3x3_r2c2_valid", int'(bus.rd_valid), 1);
`endif
        do_read('{"rd_3x3_r1c0", 4'd3, 4'd3, 3'd0, 3'd1, 3'd0, 1'b1, 1'b0, 8'd51});

        // Reset mid-session after 3 elements
        bus.wr_start = 1'b1; bus.wr_m = 4'd2; bus.wr_n = 4'd2;
        step();
        bus.wr_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(200 + k);
            step();
        end
        bus.wr_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (bus.wr_done) seen = 1'b1;
            step();
        end
        chk("rst_mid_no_wr_done", int'(seen), 0);
        chk("rst_mid_busy",       int'(bus.busy), 0);
        bus.q_m = 4'd2; bus.q_n = 4'd2; #1;
        chk("rst_mid_q2x2_mask",  int'(bus.q_mask),  0);
        chk("rst_mid_q2x2_count", int'(bus.q_count), 0);
        bus.q_m = 4'd2; bus.q_n = 4'd3; #1;
        chk("rst_mid_q2x3_mask",  int'(bus.q_mask),  0);
        do_read('{"rd_after_rst", 4'd2, 4'd3, 3'd0, 3'd1, 3'd2, 1'b0, 1'b1, 8'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
